// File: rtl/riscv_hz_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Contents: FSM state enum, multi-cycle down-counter width, register
// index width and the x0 register index.
package riscv_hz_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } hz_state_e;

    localparam int unsigned MC_CNT_W = 4;
    localparam int unsigned REG_W    = 5;
    localparam logic [REG_W-1:0] X0  = 5'd0;

endpackage

// File: rtl/hz_sat_cnt.sv
// Saturating up-counter used for the hazard performance statistics.
// Ports:
//   clk   - clock
//   rstn  - asynchronous active-low reset, clears the count
//   inc   - add one this cycle (ignored once the count is all-ones)
//   cnt   - current count
module hz_sat_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    // Count up and hold at all-ones.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32 core.
// Detects load-use hazards and taken branches resolved in EX, and sequences
// multi-cycle EX operations. Hazard outputs are combinational from state and
// inputs; the ID/EX register samples id_ex_flush at the next clk edge.
// Optional macro: HAZARD_PERF_EN adds three saturating perf counters; when
// undefined the counter ports are tied to zero.
// Ports:
//   clk, rstn                       - clock, async active-low reset
//   id_rs1, id_rs2, id_use_rs1/2    - source operands of the ID instruction
//   ex_rd, ex_mem_read              - destination / load flag of EX instruction
//   ex_br_taken                     - taken branch redirect from EX
//   mc_start                        - multi-cycle op entering EX (pulse)
//   pc_stall, if_id_stall           - hold PC / IF-ID
//   if_id_flush, id_ex_flush        - squash IF-ID / bubble into ID-EX
//   id_ex_hold                      - hold ID-EX contents
//   mc_last                         - final stall cycle of a multi-cycle op
//   hz_busy                         - multi-cycle sequencing in progress
//   lu_stall_cnt, br_flush_cnt, mc_stall_cnt - perf counters
module hazard_ctrl
    import riscv_hz_pkg::*;
#(
    parameter int unsigned MC_LAT = 4,
    parameter int unsigned CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_br_taken,
    input  logic             mc_start,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             id_ex_hold,
    output logic             mc_last,
    output logic             hz_busy,
    output logic [CNT_W-1:0] lu_stall_cnt,
    output logic [CNT_W-1:0] br_flush_cnt,
    output logic [CNT_W-1:0] mc_stall_cnt
);

    if ((MC_LAT < 2) || (MC_LAT > 16)) begin : g_bad_lat
        $error("hazard_ctrl: MC_LAT out of range 2..16");
    end

    localparam logic [MC_CNT_W-1:0] MC_LOAD = MC_CNT_W'(MC_LAT - 2);

    hz_state_e           state;
    logic [MC_CNT_W-1:0] cnt;
    logic                lu;

    // Load-use: EX load writes a register the ID instruction actually reads.
    assign lu = ex_mem_read && (ex_rd != X0) &&
                ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                 (id_use_rs2 && (id_rs2 == ex_rd)));

    assign hz_busy = (state == MC_BUSY);

    // State register and multi-cycle down-counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            case (state)
                RUN: begin
                    // A taken branch squashes the op on the wrong path.
                    if (!ex_br_taken && mc_start) begin
                        state <= MC_BUSY;
                        cnt   <= MC_LOAD;
                    end
                end
                MC_BUSY: begin
                    if (cnt == '0) begin
                        state <= RUN;
                    end else begin
                        cnt <= cnt - MC_CNT_W'(1);
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Mealy hazard outputs, priority branch > multi-cycle > load-use.
    always_comb begin
        pc_stall    = 1'b0;
        if_id_stall = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        id_ex_hold  = 1'b0;
        mc_last     = 1'b0;
        case (state)
            RUN: begin
                if (ex_br_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (mc_start) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_hold  = 1'b1;
                end else if (lu) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_flush = 1'b1;
                end
            end
            MC_BUSY: begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_hold  = 1'b1;
                mc_last     = (cnt == '0);
            end
            default: begin
            end
        endcase
    end

`ifdef HAZARD_PERF_EN
    logic lu_inc;
    logic br_inc;

    assign lu_inc = (state == RUN) && lu && !ex_br_taken && !mc_start;
    assign br_inc = (state == RUN) && ex_br_taken;

    hz_sat_cnt #(.CNT_W(CNT_W)) u_lu_cnt (
        .clk  (clk),
        .rstn (rstn),
        .inc  (lu_inc),
        .cnt  (lu_stall_cnt)
    );

    hz_sat_cnt #(.CNT_W(CNT_W)) u_br_cnt (
        .clk  (clk),
        .rstn (rstn),
        .inc  (br_inc),
        .cnt  (br_flush_cnt)
    );

    hz_sat_cnt #(.CNT_W(CNT_W)) u_mc_cnt (
        .clk  (clk),
        .rstn (rstn),
        .inc  (id_ex_hold),
        .cnt  (mc_stall_cnt)
    );
`else
    assign lu_stall_cnt = '0;
    assign br_flush_cnt = '0;
    assign mc_stall_cnt = '0;
`endif

`ifndef SYNTHESIS
    // Branch and multi-cycle start together is an illegal input combination.
    a_br_mc_excl: assert property (@(posedge clk) disable iff (!rstn)
        !(ex_br_taken && mc_start))
        else $error("hazard_ctrl: mc_start with ex_br_taken");

    a_flush_hold_excl: assert property (@(posedge clk) disable iff (!rstn)
        !(id_ex_flush && id_ex_hold))
        else $error("hazard_ctrl: id_ex_flush with id_ex_hold");
`endif

endmodule
